// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the
// CPU MEM stage (port A) and the debug/loader port (port B).
module dmem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          gnt_a,
    output logic          done_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_b,
    output logic          done_b,
    output logic [DW-1:0] rdata_b,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t        state;
    state_t        state_nx;
    logic          last;
    logic          own;
    logic          lat_we;
    logic [CW-1:0] cnt;
    logic          any_req;
    logic          pick_b;
    logic          cnt_end;

    // last=1 means port B was served most recently
    always_comb begin
        any_req = req_a | req_b;
        pick_b  = req_b & (~req_a | ~last);
        cnt_end = (cnt == CW'(RD_LAT - 1));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = ISSUE;
            ISSUE:   state_nx = lat_we ? RESP : WAIT;
            WAIT:    if (cnt_end) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        gnt_a  = (state == IDLE) & ~rst & any_req & ~pick_b;
        gnt_b  = (state == IDLE) & ~rst & pick_b;
        mem_we = (state == ISSUE) & lat_we;
        mem_re = (state == ISSUE) & ~lat_we;
        done_a = (state == RESP) & ~own;
        done_b = (state == RESP) & own;
        busy   = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            own       <= 1'b0;
            lat_we    <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_a   <= '0;
            rdata_b   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                own       <= pick_b;
                last      <= pick_b;
                lat_we    <= pick_b ? we_b : we_a;
                mem_addr  <= pick_b ? addr_b : addr_a;
                mem_wdata <= pick_b ? wdata_b : wdata_a;
            end
            if (state == ISSUE)
                cnt <= '0;
            else if (state == WAIT)
                cnt <= cnt + 1'b1;
            if (state == WAIT && cnt_end) begin
                if (own)
                    rdata_b <= mem_rdata;
                else
                    rdata_a <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port A (CPU MEM stage) and port B (debug/loader port used for preload and dump).
- Round-robin arbitration, one access in flight at a time.
- Sequences the memory strobes (mem_we/mem_re) and returns read data with a done pulse to the owning requester.
- Sits between the CPU pipeline/debug logic and the data memory.

Parameters:
AW, 32, address width
DW, 32, data width
RD_LAT, 1, cycles from the issue cycle until mem_rdata is valid (must be >=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
req_a  input  1  port A request; held stable until gnt_a
we_a  input  1  port A: 1=write, 0=read
addr_a  input  AW  port A address
wdata_a  input  DW  port A write data
gnt_a  output  1  one-cycle pulse: port A request accepted
done_a  output  1  one-cycle pulse: port A access complete
rdata_a  output  DW  port A read data, valid with done_a, held until next port A read completes
req_b, we_b, addr_b, wdata_b  input  1/1/AW/DW  port B, same as port A
gnt_b, done_b, rdata_b  output  1/1/DW  port B, same as port A
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_we  output  1  memory write strobe
mem_re  output  1  memory read strobe
mem_rdata  input  DW  memory read data
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async):
  - state=IDLE; every output =0, including rdata_a/b and mem_* buses.
  - Round-robin pointer last=B, so A wins the first tie.
  - Any in-flight access is dropped with no done pulse.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE (cycle N):
  - If any req is high, select the winner.
  - Latch the winner's we/addr/wdata and owner ID.
  - Pulse the winner's gnt in cycle N (combinational from req and pointer).
  - Set last=winner. Go to ISSUE.
  - No req: stay in IDLE.
- Arbitration:
  - Single requester wins regardless of the pointer.
  - Both requesting: grant the port not equal to last.
- ISSUE (N+1):
  - mem_addr/mem_wdata driven from the latch; mem_we=latched we, mem_re=~latched we, for exactly this cycle.
  - Write -> RESP. Read -> WAIT.
- WAIT (N+2 .. N+1+RD_LAT):
  - Count RD_LAT cycles; strobes low.
  - On the last WAIT edge, capture mem_rdata into the owner's rdata register. Go to RESP.
- RESP:
  - Owner's done pulses for one cycle; state returns to IDLE.
  - Write: done at N+2. Read: done at N+2+RD_LAT.
- Next arbitration: earliest in the cycle after RESP, so minimum spacing between gnts is 3 cycles (write) or 3+RD_LAT cycles (read).
- mem_addr/mem_wdata: hold latched values outside ISSUE. mem_we and mem_re are never high simultaneously and are never high outside ISSUE.
- Requests arriving while busy are not granted until IDLE; the loser keeps req asserted and is granted at the next IDLE (pointer guarantees no starvation).
- req deasserted before gnt: request withdrawn, no side effects.
- Requester may change req/addr/data freely from the cycle after gnt.
- rdata of the non-owner port never changes; writes never modify rdata.
- Reset asserted mid-access: immediate return to reset state; reset during ISSUE leaves mem_we=0 (no partial write is completed by this block).

Test Plan:
- Reset then A write (addr=4, wdata=32'd3): gnt_a at N, mem_we=1/mem_addr=4 at N+1 only, done_a at N+2, busy high N+1..N+2.
- A read (addr=4), mem model returns 32'd3 with RD_LAT=1: mem_re at N+1, done_a at N+3 with rdata_a=3; rdata_b stays 0.
- req_a and req_b asserted together, held, after reset: A granted first, B granted in the first IDLE after done_a. Then both again: A granted (last=B), strictly alternating over 6 accesses.
- req_b held while A access in flight: no gnt_b until after done_a; gnt_b in the following cycle; B read addr=8 returns 32'd7 on rdata_b.
- RD_LAT=3 build, B read: done_b at N+5; mem_re high only at N+1; never mem_we&mem_re.
- rst pulsed in ISSUE of an A write: all outputs 0 immediately; no done_a; next req_b granted in the first cycle after rst falls.
